hamming_secded_link: RTL and testbench
======================================

# hamming_secded_link

Parametrised, pipelined Hamming SECDED channel with a valid/ready handshake. Each accepted data word is encoded, optionally corrupted by a programmable single- or double-bit error, then decoded and corrected. The block also keeps saturating counts of corrected and uncorrectable words. It is the clocked successor of the combinational 12-bit encode/noise/decode top, and it is the standard error-injection and self-test path for link and memory models in the design.

## Interface
- DATA_W, 12: payload width; legal range 4..57.
- CNT_W, 16: width of each error counter.
- P (localparam): smallest integer with 2^P >= DATA_W+P+1. P = 5 when DATA_W = 12.
- CW_W (localparam): DATA_W+P+1. CW_W = 18 when DATA_W = 12.
- clk, in, 1: single clock; all logic is rising-edge.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: input word valid.
- in_ready, out, 1: block can accept a word.
- in_data, in, DATA_W: payload.
- inj_mode, in, 2: error injection mode, sampled with the word. 00 = none, 01 = single, 10 = double, 11 = none.
- inj_pos0, in, 8: first codeword bit to flip.
- inj_pos1, in, 8: second codeword bit to flip (mode 10 only).
- out_valid, out, 1: output word valid.
- out_ready, in, 1: downstream accepts the word.
- out_data, out, DATA_W: decoded and, where possible, corrected payload.
- out_corrected, out, 1: a single-bit error was corrected.
- out_uncorrectable, out, 1: a double error was detected.
- corr_cnt, out, CNT_W: saturating count of corrected words.
- uncorr_cnt, out, CNT_W: saturating count of uncorrectable words.
- cnt_clr, in, 1: synchronous clear of both counters.

## Operation
- Codeword layout:
  - Bit 0 is overall parity, the XOR of bits 1..CW_W-1.
  - Bits at power-of-two positions 1, 2, 4, … are Hamming parity bits.
  - Parity bit 2^k is the XOR of all positions j ≥ 1 with bit k set.
  - Data fills the remaining positions in ascending order, in_data[0] first.
- Stage 1 (encode/inject), loaded on an input handshake:
  - Build the codeword.
  - Mode 01: flip bit inj_pos0.
  - Mode 10: flip bits inj_pos0 and inj_pos1.
  - A position ≥ CW_W is ignored and causes no flip.
  - Mode 10 with inj_pos0 == inj_pos1 flips that bit once, i.e. it behaves as mode 01.
- Stage 2 (decode):
  - S = P-bit syndrome; Q = XOR of all CW_W bits.
  - S = 0, Q = 0: clean. Both flags are 0.
  - Q = 1, S = 0: the error is in bit 0. Data is unchanged; out_corrected = 1.
  - Q = 1, 0 < S < CW_W: flip bit S, extract data; out_corrected = 1.
  - Q = 1, S ≥ CW_W: out_uncorrectable = 1.
  - Q = 0, S ≠ 0: out_uncorrectable = 1.
  - Whenever uncorrectable, out_data is the raw extracted data, not corrected.
- Counters:
  - Update only on an output handshake (out_valid && out_ready).
  - Increment by the flag of the word being handed off.
  - Saturate at 2^CNT_W-1.
  - cnt_clr takes priority over an increment in the same cycle.

## Timing
- Reset (rst_n low, asynchronous): both stage-valid registers are 0, out_data = 0, both flags = 0, both counters = 0. in_ready is 1 after reset.
- Latency: 2 cycles from an input handshake to out_valid with no backpressure. Throughput is 1 word per cycle.
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready and state).
- Output hold: while out_valid && !out_ready, out_data and both flags hold stable and no word is lost. Two words are buffered at most.
- in_valid may drop without a handshake. Injection inputs matter only in a handshake cycle.
- Reset asserted mid-stream discards all in-flight words. The first output after release is the first word accepted after release.

## Test plan
- DATA_W = 12, in_data = 12'hA5C, mode 00, out_ready = 1 -> after 2 cycles out_data = 12'hA5C, both flags 0, counters unchanged.
- in_data = 12'h3C7, mode 01, pos0 = 0, then 7, then 17 (three words) -> each output is 12'h3C7 with out_corrected = 1; corr_cnt = 3.
- in_data = 12'hFFF, mode 10, pos0 = 3, pos1 = 9 -> out_uncorrectable = 1, out_corrected = 0, uncorr_cnt = 1. Repeat with pos0 = pos1 = 9 -> out_data = 12'hFFF, out_corrected = 1.
- Mode 01 with pos0 = 18 and pos0 = 200 -> clean output, no flags.
- Stream 5 words back-to-back, hold out_ready = 0 for 4 cycles -> in_ready falls after 2 accepted words, output stays stable, all 5 words emerge in order with none duplicated.
- CNT_W = 2, inject 5 single errors -> corr_cnt saturates at 3. Assert cnt_clr together with a corrected handshake -> corr_cnt = 0. Pulse rst_n low mid-stream -> outputs and counters are 0 immediately.

Source files
------------

// File: rtl/hamming_secded_link.sv
// hamming_secded_link
// Two-stage Hamming SECDED channel with a valid/ready handshake. Stage 1
// encodes the accepted payload and applies the requested error injection.
// Stage 2 decodes, corrects single-bit errors and flags double errors.
// Saturating counters track corrected and uncorrectable words.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   input handshake and payload
//   inj_mode, inj_pos0/1        error injection control, sampled with the word
//   out_valid/out_ready         output handshake
//   out_data                    decoded (and, where possible, corrected) payload
//   out_corrected               single-bit error was corrected
//   out_uncorrectable           double error detected
//   corr_cnt, uncorr_cnt        saturating error counters
//   cnt_clr                     synchronous counter clear, wins over increments
module hamming_secded_link #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        inj_mode,
  input  logic [7:0]        inj_pos0,
  input  logic [7:0]        inj_pos1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corrected,
  output logic              out_uncorrectable,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  input  logic              cnt_clr
);

  // Smallest P with 2^P >= DATA_W + P + 1; the test is monotonic in i.
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    for (int i = 1; i < 8; i++) begin
      if ((1 << i) < dw + i + 1) p = i + 1;
    end
    return p;
  endfunction

  localparam int P    = calc_p(DATA_W);
  localparam int CW_W = DATA_W + P + 1;

  function automatic logic is_pow2(input int j);
    return (j & (j - 1)) == 0;
  endfunction

  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0]   cw;
    logic [DATA_W-1:0] d_sh;
    logic              par;
    cw   = '0;
    d_sh = d;
    for (int j = 1; j < CW_W; j++) begin
      if (!is_pow2(j)) begin
        cw[j] = d_sh[0];
        d_sh  = d_sh >> 1;
      end
    end
    // Parity positions are still zero here and no other parity position
    // shares bit k with 2^k, so each group XOR sees only data bits.
    for (int k = 0; k < P; k++) begin
      par = 1'b0;
      for (int j = 1; j < CW_W; j++) begin
        if (((j >> k) & 1) == 1) par = par ^ cw[j];
      end
      cw[1 << k] = par;
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

  logic              s1_valid;
  logic [CW_W-1:0]   s1_cw;
  logic              s1_adv;
  logic              s2_adv;
  logic [CW_W-1:0]   inj_mask;
  logic [CW_W-1:0]   enc_cw;
  logic [P-1:0]      syn;
  logic              q_par;
  logic [CW_W-1:0]   fixed_cw;
  logic [DATA_W-1:0] dec_data;
  logic              dec_corr;
  logic              dec_unc;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Mask bits are OR-ed, so equal positions in double mode flip only once;
  // out-of-range positions never match any index.
  always_comb begin
    inj_mask = '0;
    for (int j = 0; j < CW_W; j++) begin
      if ((inj_mode == 2'b01 || inj_mode == 2'b10) && int'(inj_pos0) == j)
        inj_mask[j] = 1'b1;
      if (inj_mode == 2'b10 && int'(inj_pos1) == j)
        inj_mask[j] = 1'b1;
    end
  end

  assign enc_cw = encode(in_data) ^ inj_mask;

  always_comb begin
    syn      = '0;
    q_par    = ^s1_cw;
    fixed_cw = s1_cw;
    dec_data = '0;
    for (int j = 1; j < CW_W; j++) begin
      if (s1_cw[j]) syn = syn ^ P'(j);
    end
    dec_unc  = (q_par && int'(syn) >= CW_W) || (!q_par && syn != '0);
    dec_corr = q_par && int'(syn) < CW_W;
    // Syndrome 0 with odd parity means bit 0 itself flipped: nothing to fix.
    for (int j = 1; j < CW_W; j++) begin
      if (dec_corr && int'(syn) == j) fixed_cw[j] = ~fixed_cw[j];
    end
    // Shift data bits in from the top so the first data position ends at bit 0.
    for (int j = 1; j < CW_W; j++) begin
      if (!is_pow2(j)) dec_data = {fixed_cw[j], dec_data[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_cw <= enc_cw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data          <= dec_data;
        out_corrected     <= dec_corr;
        out_uncorrectable <= dec_unc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_corrected && corr_cnt != '1)
        corr_cnt <= corr_cnt + CNT_W'(1);
      if (out_uncorrectable && uncorr_cnt != '1)
        uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_link.sv
// tb_hamming_secded_link
// Self-checking bench for hamming_secded_link (DATA_W = 12, CNT_W = 2).
// Expected outputs come from a flip-count model of the SECDED rules: zero
// flips -> clean, one flip -> corrected payload, two flips -> uncorrectable
// with the flipped data bits visible in the raw payload.
module tb_hamming_secded_link;

  localparam int DATA_W  = 12;
  localparam int CNT_W   = 2;
  localparam int CW_W    = 18;
  localparam int CNT_MAX = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        inj_mode;
  logic [7:0]        inj_pos0;
  logic [7:0]        inj_pos1;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_corrected;
  logic              out_uncorrectable;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;
  logic              cnt_clr;

  hamming_secded_link #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .inj_mode          (inj_mode),
    .inj_pos0          (inj_pos0),
    .inj_pos1          (inj_pos1),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .corr_cnt          (corr_cnt),
    .uncorr_cnt        (uncorr_cnt),
    .cnt_clr           (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corr;
    logic              unc;
  } exp_t;

  exp_t              exp_q[$];
  int                n_chk;
  int                n_fail;
  int                data_pos[DATA_W];
  int                m_corr;
  int                m_unc;
  int                n_out;
  logic              hold_v;
  logic [DATA_W+1:0] hold_bits;
  logic [DATA_W-1:0] last_data;
  logic              last_corr;
  logic              last_unc;
  logic              rnd_done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [DATA_W-1:0] d, input logic [1:0] mode,
                                 input int p0, input int p1);
    exp_t e;
    int   f0;
    int   f1;
    int   n;
    f0 = -1;
    f1 = -1;
    if ((mode == 2'b01 || mode == 2'b10) && p0 < CW_W) f0 = p0;
    if (mode == 2'b10 && p1 < CW_W && p1 != p0) f1 = p1;
    n = 0;
    if (f0 >= 0) n++;
    if (f1 >= 0) n++;
    e.data = d;
    e.corr = (n == 1);
    e.unc  = (n == 2);
    if (n == 2) begin
      for (int i = 0; i < DATA_W; i++)
        if (data_pos[i] == f0 || data_pos[i] == f1) e.data[i] = ~e.data[i];
    end
    return e;
  endfunction

  initial begin
    int k;
    k = 0;
    for (int pos = 1; k < DATA_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        data_pos[k] = pos;
        k++;
      end
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    m_corr = 0;
    m_unc  = 0;
    hold_v = 1'b0;
  end

  // Monitor: at each falling edge, predict what the next rising edge does.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_eq("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
        check_eq("corr_cnt", corr_cnt, m_corr);
        check_eq("uncorr_cnt", uncorr_cnt, m_unc);
        if (hold_v) begin
          check_eq("hold_valid", out_valid, 1);
          check_eq("hold_data", {out_data, out_corrected, out_uncorrectable}, hold_bits);
        end
        hold_v    = out_valid && !out_ready;
        hold_bits = {out_data, out_corrected, out_uncorrectable};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("out_unexpected", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("out_data", out_data, e.data);
            check_eq("out_corrected", out_corrected, e.corr);
            check_eq("out_uncorrectable", out_uncorrectable, e.unc);
            last_data = out_data;
            last_corr = out_corrected;
            last_unc  = out_uncorrectable;
            n_out++;
            if (e.corr && m_corr < CNT_MAX) m_corr++;
            if (e.unc && m_unc < CNT_MAX) m_unc++;
          end
        end
        if (cnt_clr) begin
          m_corr = 0;
          m_unc  = 0;
        end
        if (in_valid && in_ready)
          exp_q.push_back(model(in_data, inj_mode, int'(inj_pos0), int'(inj_pos1)));
      end
    end
  end

  // Called at rising edge + 1; returns at rising edge + 1 after the handshake.
  task automatic send(input logic [DATA_W-1:0] d, input logic [1:0] m,
                      input logic [7:0] p0, input logic [7:0] p1);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    inj_mode = m;
    inj_pos0 = p0;
    inj_pos1 = p1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    inj_mode = 2'($urandom);
    inj_pos0 = 8'($urandom);
    inj_pos1 = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
  endtask

  function automatic logic [7:0] rand_pos();
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(CW_W, 255));
    return 8'($urandom_range(0, CW_W - 1));
  endfunction

  initial begin
    int n0;
    n_chk = 0; n_fail = 0; n_out = 0;
    m_corr = 0; m_unc = 0; hold_v = 1'b0; rnd_done = 1'b0;
    last_data = '0; last_corr = 1'b0; last_unc = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; inj_mode = 2'b00;
    inj_pos0 = '0; inj_pos1 = '0; out_ready = 1'b1; cnt_clr = 1'b0;

    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_flags", {out_corrected, out_uncorrectable}, 0);
    check_eq("rst_counters", {corr_cnt, uncorr_cnt}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_in_ready", in_ready, 1);

    // Clean word, two-cycle latency.
    send(12'hA5C, 2'b00, 8'd0, 8'd0);
    check_eq("latency_early", out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("latency_valid", out_valid, 1);
    check_eq("clean_data", out_data, 12'hA5C);
    check_eq("clean_flags", {out_corrected, out_uncorrectable}, 0);
    drain();
    check_eq("clean_cnt", {corr_cnt, uncorr_cnt}, 0);

    // Single errors at overall parity, a data bit and the top bit.
    clear_counters();
    send(12'h3C7, 2'b01, 8'd0, 8'd0);
    send(12'h3C7, 2'b01, 8'd7, 8'd0);
    send(12'h3C7, 2'b01, 8'd17, 8'd0);
    drain();
    check_eq("single_last_data", last_data, 12'h3C7);
    check_eq("single_corr_cnt", corr_cnt, 3);

    // Double error, then double mode with equal positions.
    clear_counters();
    send(12'hFFF, 2'b10, 8'd3, 8'd9);
    drain();
    check_eq("double_flags", {last_corr, last_unc}, 2'b01);
    check_eq("double_uncorr_cnt", uncorr_cnt, 1);
    send(12'hFFF, 2'b10, 8'd9, 8'd9);
    drain();
    check_eq("same_pos_data", last_data, 12'hFFF);
    check_eq("same_pos_flags", {last_corr, last_unc}, 2'b10);

    // Out-of-range positions cause no flip.
    clear_counters();
    send(12'h5A3, 2'b01, 8'd18, 8'd0);
    send(12'h5A3, 2'b01, 8'd200, 8'd0);
    drain();
    check_eq("oor_flags", {last_corr, last_unc}, 0);
    check_eq("oor_cnt", {corr_cnt, uncorr_cnt}, 0);

    // Backpressure: two words fill the pipe, then in_ready drops.
    n0 = n_out;
    out_ready = 1'b0;
    send(12'h101, 2'b00, 8'd0, 8'd0);
    send(12'h202, 2'b01, 8'd4, 8'd0);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_out_valid", out_valid, 1);
    fork
      begin
        send(12'h303, 2'b10, 8'd1, 8'd12);
        send(12'h404, 2'b00, 8'd0, 8'd0);
        send(12'h505, 2'b01, 8'd11, 8'd0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("bp_count", n_out - n0, 5);

    // Saturation and clear-over-increment.
    clear_counters();
    for (int i = 0; i < 5; i++)
      send(DATA_W'($urandom), 2'b01, 8'($urandom_range(0, CW_W - 1)), 8'd0);
    drain();
    check_eq("sat_corr_cnt", corr_cnt, CNT_MAX);
    out_ready = 1'b0;
    send(12'h777, 2'b01, 8'd6, 8'd0);
    @(posedge clk);
    #1;
    check_eq("clr_pre_valid", out_valid, 1);
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check_eq("clr_priority", corr_cnt, 0);

    // Reset mid-stream.
    send(12'h0F0, 2'b01, 8'd5, 8'd0);
    send(12'h0F1, 2'b01, 8'd5, 8'd0);
    drain();
    check_eq("pre_rst_cnt", corr_cnt, 2);
    send(12'hABC, 2'b01, 8'd5, 8'd0);
    send(12'hDEF, 2'b00, 8'd0, 8'd0);
    check_eq("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_data", out_data, 0);
    check_eq("mid_rst_flags", {out_corrected, out_uncorrectable}, 0);
    check_eq("mid_rst_cnt", {corr_cnt, uncorr_cnt}, 0);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = n_out;
    send(12'h123, 2'b00, 8'd0, 8'd0);
    drain();
    check_eq("post_rst_count", n_out - n0, 1);
    check_eq("post_rst_data", last_data, 12'h123);

    // Randomized traffic with random backpressure and counter clears.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(DATA_W'($urandom), 2'($urandom), rand_pos(), rand_pos());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          cnt_clr   = ($urandom_range(0, 15) == 0);
        end
      end
    join
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
